// File: rtl/core_pkg.sv
// Shared core types for the decode->execute boundary: widths and packed lane bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int OPCODE_W  = 7;
    localparam int ALU_OP_W  = 3;
    localparam int FUNCT3_W  = 3;

    // Control bits produced by decode and consumed by execute/mem/wb.
    typedef struct packed {
        logic                reg_write;
        logic                is_imm;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic [ALU_OP_W-1:0] alu_op;
        logic                jump;
        logic                branch;
        logic                U_type;
    } id_ex_ctrl_t;

    // Everything in the ID/EX register that is not an XLEN-wide data lane.
    typedef struct packed {
        id_ex_ctrl_t          ctrl;
        logic [FUNCT3_W-1:0]  funct3;
        logic                 funct7b5;
        logic [REG_IDX_W-1:0] rd;
        logic [OPCODE_W-1:0]  op;
    } id_ex_meta_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline flop with synchronous reset-to-zero (flush/stall with ID_EX_HAZARD_EN).
// Latency: 1 cycle, q driven straight from the flop.
// Backpressure: none in the base build; stall holds q, flush loads zero (ID_EX_HAZARD_EN).
//
// Ports: clk, rst (sync, active-high), [flush, stall], d (W), q (W).
// Optional feature macro: ID_EX_HAZARD_EN.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef ID_EX_HAZARD_EN
    input  logic         flush,
    input  logic         stall,
`endif
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
`ifdef ID_EX_HAZARD_EN
        end else if (flush) begin
            // Flush wins over stall so a squashed instruction never lingers.
            q <= '0;
        end else if (!stall) begin
            q <= d;
`else
        end else begin
            q <= d;
`endif
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: registers operands, immediate, PC, rd, opcode and control bits.
// Latency: exactly 1 cycle, outputs straight from flops, reset/flush clear to a bubble.
// Backpressure: none in the base build; ID_EX_HAZARD_EN adds stall (hold) and flush (bubble).
//
// Ports: clk, rst (sync, active-high); paired *_in_id_ex / *_out_id_ex lanes for imm, rd_1,
// rd_2, pc (XLEN), the control bits, alu_op (3), rd (5), op (7); funct3_in/out, funct7b5_in/out.
// Optional feature macro: ID_EX_HAZARD_EN (adds stall_id_ex, flush_id_ex inputs).
module id_ex_pipe_reg
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ID_EX_HAZARD_EN
    input  logic                 stall_id_ex,
    input  logic                 flush_id_ex,
`endif
    input  logic [XLEN-1:0]      imm_in_id_ex,
    input  logic [XLEN-1:0]      rd_1_in_id_ex,
    input  logic [XLEN-1:0]      rd_2_in_id_ex,
    input  logic [XLEN-1:0]      pc_in_id_ex,
    input  logic                 reg_write_in_id_ex,
    input  logic                 is_imm_in_id_ex,
    input  logic                 mem_read_in_id_ex,
    input  logic                 mem_write_in_id_ex,
    input  logic                 mem_to_reg_in_id_ex,
    input  logic [ALU_OP_W-1:0]  alu_op_in_id_ex,
    input  logic                 jump_in_id_ex,
    input  logic                 branch_in_id_ex,
    input  logic                 U_type_in_id_ex,
    input  logic [FUNCT3_W-1:0]  funct3_in,
    input  logic                 funct7b5_in,
    input  logic [REG_IDX_W-1:0] rd_in_id_ex,
    input  logic [OPCODE_W-1:0]  op_in_id_ex,
    output logic [XLEN-1:0]      imm_out_id_ex,
    output logic [XLEN-1:0]      rd_1_out_id_ex,
    output logic [XLEN-1:0]      rd_2_out_id_ex,
    output logic [XLEN-1:0]      pc_out_id_ex,
    output logic                 reg_write_out_id_ex,
    output logic                 is_imm_out_id_ex,
    output logic                 mem_read_out_id_ex,
    output logic                 mem_write_out_id_ex,
    output logic                 mem_to_reg_out_id_ex,
    output logic [ALU_OP_W-1:0]  alu_op_out_id_ex,
    output logic                 jump_out_id_ex,
    output logic                 branch_out_id_ex,
    output logic                 U_type_out_id_ex,
    output logic [FUNCT3_W-1:0]  funct3_out,
    output logic                 funct7b5_out,
    output logic [REG_IDX_W-1:0] rd_out_id_ex,
    output logic [OPCODE_W-1:0]  op_out_id_ex
);

    localparam int DATA_W = 4 * XLEN;
    localparam int META_W = $bits(id_ex_meta_t);

    // Data lanes are kept outside the struct so an XLEN override stays consistent.
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    id_ex_meta_t       meta_d;
    id_ex_meta_t       meta_q;

    assign data_d = {imm_in_id_ex, rd_1_in_id_ex, rd_2_in_id_ex, pc_in_id_ex};

    always_comb begin
        meta_d                 = '0;
        meta_d.ctrl.reg_write  = reg_write_in_id_ex;
        meta_d.ctrl.is_imm     = is_imm_in_id_ex;
        meta_d.ctrl.mem_read   = mem_read_in_id_ex;
        meta_d.ctrl.mem_write  = mem_write_in_id_ex;
        meta_d.ctrl.mem_to_reg = mem_to_reg_in_id_ex;
        meta_d.ctrl.alu_op     = alu_op_in_id_ex;
        meta_d.ctrl.jump       = jump_in_id_ex;
        meta_d.ctrl.branch     = branch_in_id_ex;
        meta_d.ctrl.U_type     = U_type_in_id_ex;
        meta_d.funct3          = funct3_in;
        meta_d.funct7b5        = funct7b5_in;
        meta_d.rd              = rd_in_id_ex;
        meta_d.op              = op_in_id_ex;
    end

    pipe_reg #(.W(DATA_W)) u_data_reg (
        .clk   (clk),
        .rst   (rst),
`ifdef ID_EX_HAZARD_EN
        .flush (flush_id_ex),
        .stall (stall_id_ex),
`endif
        .d     (data_d),
        .q     (data_q)
    );

    pipe_reg #(.W(META_W)) u_meta_reg (
        .clk   (clk),
        .rst   (rst),
`ifdef ID_EX_HAZARD_EN
        .flush (flush_id_ex),
        .stall (stall_id_ex),
`endif
        .d     (meta_d),
        .q     (meta_q)
    );

    assign imm_out_id_ex        = data_q[4*XLEN-1:3*XLEN];
    assign rd_1_out_id_ex       = data_q[3*XLEN-1:2*XLEN];
    assign rd_2_out_id_ex       = data_q[2*XLEN-1:XLEN];
    assign pc_out_id_ex         = data_q[XLEN-1:0];

    assign reg_write_out_id_ex  = meta_q.ctrl.reg_write;
    assign is_imm_out_id_ex     = meta_q.ctrl.is_imm;
    assign mem_read_out_id_ex   = meta_q.ctrl.mem_read;
    assign mem_write_out_id_ex  = meta_q.ctrl.mem_write;
    assign mem_to_reg_out_id_ex = meta_q.ctrl.mem_to_reg;
    assign alu_op_out_id_ex     = meta_q.ctrl.alu_op;
    assign jump_out_id_ex       = meta_q.ctrl.jump;
    assign branch_out_id_ex     = meta_q.ctrl.branch;
    assign U_type_out_id_ex     = meta_q.ctrl.U_type;
    assign funct3_out           = meta_q.funct3;
    assign funct7b5_out         = meta_q.funct7b5;
    assign rd_out_id_ex         = meta_q.rd;
    assign op_out_id_ex         = meta_q.op;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vectors with literal expectations plus randomized traffic.
// Latency: a reference value of the register is updated at each rising edge and compared on falling edges.
// Backpressure: stall/flush stimulus only when ID_EX_HAZARD_EN is defined.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] rd_1;
        logic [31:0] rd_2;
        logic [31:0] pc;
        logic        reg_write;
        logic        is_imm;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [2:0]  alu_op;
        logic        jump;
        logic        branch;
        logic        u_type;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic [6:0]  op;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_stall = 1'b0;
    logic tb_flush = 1'b0;
    vec_t vin = '0;
    vec_t vout;

    logic [31:0] imm_o, rd_1_o, rd_2_o, pc_o;
    logic        reg_write_o, is_imm_o, mem_read_o, mem_write_o, mem_to_reg_o;
    logic [2:0]  alu_op_o;
    logic        jump_o, branch_o, u_type_o;
    logic [2:0]  funct3_o;
    logic        funct7b5_o;
    logic [4:0]  rd_o;
    logic [6:0]  op_o;

    assign vout = {imm_o, rd_1_o, rd_2_o, pc_o, reg_write_o, is_imm_o, mem_read_o,
                   mem_write_o, mem_to_reg_o, alu_op_o, jump_o, branch_o, u_type_o,
                   funct3_o, funct7b5_o, rd_o, op_o};

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk                  (clk),
        .rst                  (rst),
`ifdef ID_EX_HAZARD_EN
        .stall_id_ex          (tb_stall),
        .flush_id_ex          (tb_flush),
`endif
        .imm_in_id_ex         (vin.imm),
        .rd_1_in_id_ex        (vin.rd_1),
        .rd_2_in_id_ex        (vin.rd_2),
        .pc_in_id_ex          (vin.pc),
        .reg_write_in_id_ex   (vin.reg_write),
        .is_imm_in_id_ex      (vin.is_imm),
        .mem_read_in_id_ex    (vin.mem_read),
        .mem_write_in_id_ex   (vin.mem_write),
        .mem_to_reg_in_id_ex  (vin.mem_to_reg),
        .alu_op_in_id_ex      (vin.alu_op),
        .jump_in_id_ex        (vin.jump),
        .branch_in_id_ex      (vin.branch),
        .U_type_in_id_ex      (vin.u_type),
        .funct3_in            (vin.funct3),
        .funct7b5_in          (vin.funct7b5),
        .rd_in_id_ex          (vin.rd),
        .op_in_id_ex          (vin.op),
        .imm_out_id_ex        (imm_o),
        .rd_1_out_id_ex       (rd_1_o),
        .rd_2_out_id_ex       (rd_2_o),
        .pc_out_id_ex         (pc_o),
        .reg_write_out_id_ex  (reg_write_o),
        .is_imm_out_id_ex     (is_imm_o),
        .mem_read_out_id_ex   (mem_read_o),
        .mem_write_out_id_ex  (mem_write_o),
        .mem_to_reg_out_id_ex (mem_to_reg_o),
        .alu_op_out_id_ex     (alu_op_o),
        .jump_out_id_ex       (jump_o),
        .branch_out_id_ex     (branch_o),
        .U_type_out_id_ex     (u_type_o),
        .funct3_out           (funct3_o),
        .funct7b5_out         (funct7b5_o),
        .rd_out_id_ex         (rd_o),
        .op_out_id_ex         (op_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference: what the execute stage must see, decided once per rising edge.
    vec_t exp_q = '0;
    bit   model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q       = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (tb_flush)      exp_q = '0;
            else if (!tb_stall) exp_q = vin;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (vout !== exp_q) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, vout, exp_q);
            end
        end
    end

    task automatic check(input string name, input vec_t exp);
        checks++;
        if (vout !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, vout, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.imm        = $urandom;
        v.rd_1       = $urandom;
        v.rd_2       = $urandom;
        v.pc         = $urandom;
        v.reg_write  = 1'($urandom_range(1));
        v.is_imm     = 1'($urandom_range(1));
        v.mem_read   = 1'($urandom_range(1));
        v.mem_write  = 1'($urandom_range(1));
        v.mem_to_reg = 1'($urandom_range(1));
        v.alu_op     = 3'($urandom_range(7));
        v.jump       = 1'($urandom_range(1));
        v.branch     = 1'($urandom_range(1));
        v.u_type     = 1'($urandom_range(1));
        v.funct3     = 3'($urandom_range(7));
        v.funct7b5   = 1'($urandom_range(1));
        v.rd         = 5'($urandom_range(31));
        v.op         = 7'($urandom_range(127));
        return v;
    endfunction

    // Returns at 2 time units after the rising edge, safely away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    vec_t va, vb, vc, vd, held;

    initial begin
        va = '{imm: 32'hA5A5A5A5, rd_1: 32'h11111111, rd_2: 32'h22222222, pc: 32'h33333333,
               reg_write: 1'b1, is_imm: 1'b1, mem_read: 1'b0, mem_write: 1'b1, mem_to_reg: 1'b0,
               alu_op: 3'b101, jump: 1'b0, branch: 1'b1, u_type: 1'b0, funct3: 3'b010,
               funct7b5: 1'b1, rd: 5'b10101, op: 7'b1101100};
        vb = '{imm: 32'hFFFF0000, rd_1: 32'h44444444, rd_2: 32'h55555555, pc: 32'h66666666,
               reg_write: 1'b0, is_imm: 1'b0, mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b1,
               alu_op: 3'b011, jump: 1'b1, branch: 1'b0, u_type: 1'b1, funct3: 3'b111,
               funct7b5: 1'b0, rd: 5'b01010, op: 7'b1010101};

        // Reset with all-zero inputs for two edges.
        rst = 1'b1;
        vin = '0;
        tick();
        tick();
        check("reset_zero_inputs", '0);

        // Reset dominates nonzero inputs.
        vin = va;
        tick();
        check("reset_nonzero_inputs", '0);

        // First capture: nothing visible before the edge, all lanes after it.
        rst = 1'b0;
        vin = va;
        #4;
        check("vec_a_before_edge", '0);
        tick();
        check("vec_a_after_edge", va);

        // Every lane toggles to the second vector one edge later.
        vin = vb;
        #4;
        check("vec_b_before_edge", va);
        tick();
        check("vec_b_after_edge", vb);

        // Mid-cycle input change is invisible until the following edge.
        #4;
        vc = rand_vec();
        vin = vc;
        #2;
        check("midcycle_hold", vb);
        tick();
        check("midcycle_capture", vc);

        // Reset while carrying data, then release and capture again.
        rst = 1'b1;
        vin = va;
        tick();
        check("midstream_reset", '0);
        rst = 1'b0;
        vd = rand_vec();
        vin = vd;
        tick();
        check("after_reset_release", vd);

`ifdef ID_EX_HAZARD_EN
        held = vd;
        tb_stall = 1'b1;
        vin = rand_vec();
        tick();
        check("stall_edge1", held);
        vin = rand_vec();
        tick();
        check("stall_edge2", held);
        tb_flush = 1'b1;
        tick();
        check("flush_over_stall", '0);
        tb_flush = 1'b0;
        tb_stall = 1'b0;
        vin = va;
        tick();
        check("resume_after_flush", va);
`else
        // Base build: back-to-back captures, no way to hold.
        held = rand_vec();
        vin = held;
        tick();
        vin = va;
        tick();
        check("no_hold_back_to_back", va);
`endif

        // Randomized traffic, scored by the reference on every falling edge.
        for (int i = 0; i < 400; i++) begin
            vin = rand_vec();
            rst = ($urandom_range(15) == 0);
`ifdef ID_EX_HAZARD_EN
            tb_stall = ($urandom_range(3) == 0);
            tb_flush = ($urandom_range(7) == 0);
`endif
            tick();
        end

        rst = 1'b0;
        tb_stall = 1'b0;
        tb_flush = 1'b0;
        vin = vb;
        tick();
        check("final_capture", vb);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
